// File: rtl/axis_pkg.sv
// Shared types and width helpers for the AXI-Stream packet FIFO.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
package axis_pkg;

   typedef enum logic [0:0] {
      ACCEPT = 1'b0,
      DROP   = 1'b1
   } axis_fifo_state_e;

   function automatic int keep_width(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Full: wrap bits differ, index bits equal.
   function automatic logic ptr_full(input logic [31:0] wp, input logic [31:0] rp, input int pw);
      logic [31:0] mask;
      logic [31:0] x;
      mask = (32'd1 << pw) - 32'd1;
      x    = (wp ^ rp) & mask;
      return x == (32'd1 << (pw - 1));
   endfunction

   function automatic logic ptr_empty(input logic [31:0] wp, input logic [31:0] rp, input int pw);
      logic [31:0] mask;
      mask = (32'd1 << pw) - 32'd1;
      return ((wp ^ rp) & mask) == 32'd0;
   endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// No reset on the array; pointer logic decides what is valid.
module axis_fifo_ram #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/axis_fifo_pkt.sv
// AXI-Stream FIFO with full sideband: FWFT beat mode, or store-and-forward packet
// mode that discards packets too large to ever fit in the buffer.
module axis_fifo_pkt
   import axis_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ID_W        = 1,
   parameter int DEST_W      = 1,
   parameter int USER_W      = 1,
   parameter int DEPTH       = 16,
   parameter int PACKET_MODE = 0
) (
   input  logic                    aclk,
   input  logic                    areset,

   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic [DATA_W-1:0]       s_axis_tdata,
   input  logic [DATA_W/8-1:0]     s_axis_tstrb,
   input  logic [DATA_W/8-1:0]     s_axis_tkeep,
   input  logic                    s_axis_tlast,
   input  logic [ID_W-1:0]         s_axis_tid,
   input  logic [DEST_W-1:0]       s_axis_tdest,
   input  logic [USER_W-1:0]       s_axis_tuser,

   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [DATA_W-1:0]       m_axis_tdata,
   output logic [DATA_W/8-1:0]     m_axis_tstrb,
   output logic [DATA_W/8-1:0]     m_axis_tkeep,
   output logic                    m_axis_tlast,
   output logic [ID_W-1:0]         m_axis_tid,
   output logic [DEST_W-1:0]       m_axis_tdest,
   output logic [USER_W-1:0]       m_axis_tuser,

   output logic [$clog2(DEPTH):0]  occupancy,
   output logic                    pkt_drop,
   output logic                    full,
   output logic                    empty
);

   localparam int KEEP_W = keep_width(DATA_W);
   localparam int PTR_W  = ptr_width(DEPTH);
   localparam int AW     = PTR_W - 1;
   localparam int BEAT_W = DATA_W + 2 * KEEP_W + 1 + ID_W + DEST_W + USER_W;

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_commit;
   axis_fifo_state_e  state;
   logic              ready_en;

   logic              push;
   logic              pop;
   logic              wr_en;
   logic              full_w;
   logic              empty_w;
   logic              drop_trig;
   logic [BEAT_W-1:0] wbeat;
   logic [BEAT_W-1:0] rbeat;

   assign full_w  = ptr_full(32'(wr_ptr), 32'(rd_ptr), PTR_W);
   assign empty_w = ptr_empty(32'(wr_ptr), 32'(rd_ptr), PTR_W);

   // Buffer full with no complete packet inside: this packet can never fit.
   assign drop_trig = (PACKET_MODE != 0) && !areset && (state == ACCEPT) &&
                      full_w && (wr_commit == rd_ptr);

   // ready_en holds tready low for the cycle following a reset edge.
   assign s_axis_tready = ready_en && ((state == DROP) || !full_w);
   assign m_axis_tvalid = (PACKET_MODE != 0) ? (rd_ptr != wr_commit) : !empty_w;

   assign push  = s_axis_tvalid && s_axis_tready;
   assign pop   = m_axis_tvalid && m_axis_tready;
   assign wr_en = push && (state == ACCEPT);

   assign occupancy = wr_ptr - rd_ptr;
   assign full      = full_w;
   assign empty     = empty_w;
   assign pkt_drop  = drop_trig;

   assign wbeat = {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast,
                   s_axis_tid, s_axis_tdest, s_axis_tuser};
   assign {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
           m_axis_tid, m_axis_tdest, m_axis_tuser} = rbeat;

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         wr_commit <= '0;
         state     <= ACCEPT;
         ready_en  <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (drop_trig) begin
            // Rewind over the partial packet; its remaining beats are swallowed in DROP.
            wr_ptr <= wr_commit;
            state  <= DROP;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (s_axis_tlast) wr_commit <= wr_ptr + 1'b1;
         end
         if ((state == DROP) && push && s_axis_tlast) state <= ACCEPT;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   axis_fifo_ram #(
      .W     (BEAT_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (aclk),
      .we    (wr_en),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (wbeat),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rbeat)
   );

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Directed bench: a DEPTH=16 beat-mode FIFO and a DEPTH=8 packet-mode FIFO
// sharing clock and reset, each scenario in its own task with inline checks.
module tb_axis_fifo_pkt;

   logic aclk;
   logic areset;

   logic        b_s_tvalid, b_s_tready, b_s_tlast;
   logic [31:0] b_s_tdata;
   logic [3:0]  b_s_tstrb, b_s_tkeep, b_s_tid, b_s_tdest, b_s_tuser;
   logic        b_m_tvalid, b_m_tready, b_m_tlast;
   logic [31:0] b_m_tdata;
   logic [3:0]  b_m_tstrb, b_m_tkeep, b_m_tid, b_m_tdest, b_m_tuser;
   logic [4:0]  b_occ;
   logic        b_drop, b_full, b_empty;

   logic        p_s_tvalid, p_s_tready, p_s_tlast;
   logic [31:0] p_s_tdata;
   logic [3:0]  p_s_tstrb, p_s_tkeep, p_s_tid, p_s_tdest, p_s_tuser;
   logic        p_m_tvalid, p_m_tready, p_m_tlast;
   logic [31:0] p_m_tdata;
   logic [3:0]  p_m_tstrb, p_m_tkeep, p_m_tid, p_m_tdest, p_m_tuser;
   logic [3:0]  p_occ;
   logic        p_drop, p_full, p_empty;

   int checks = 0;
   int errors = 0;

   axis_fifo_pkt #(.DATA_W(32), .ID_W(4), .DEST_W(4), .USER_W(4), .DEPTH(16), .PACKET_MODE(0)) u_beat (
      .aclk(aclk), .areset(areset),
      .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready), .s_axis_tdata(b_s_tdata),
      .s_axis_tstrb(b_s_tstrb), .s_axis_tkeep(b_s_tkeep), .s_axis_tlast(b_s_tlast),
      .s_axis_tid(b_s_tid), .s_axis_tdest(b_s_tdest), .s_axis_tuser(b_s_tuser),
      .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready), .m_axis_tdata(b_m_tdata),
      .m_axis_tstrb(b_m_tstrb), .m_axis_tkeep(b_m_tkeep), .m_axis_tlast(b_m_tlast),
      .m_axis_tid(b_m_tid), .m_axis_tdest(b_m_tdest), .m_axis_tuser(b_m_tuser),
      .occupancy(b_occ), .pkt_drop(b_drop), .full(b_full), .empty(b_empty)
   );

   axis_fifo_pkt #(.DATA_W(32), .ID_W(4), .DEST_W(4), .USER_W(4), .DEPTH(8), .PACKET_MODE(1)) u_pkt (
      .aclk(aclk), .areset(areset),
      .s_axis_tvalid(p_s_tvalid), .s_axis_tready(p_s_tready), .s_axis_tdata(p_s_tdata),
      .s_axis_tstrb(p_s_tstrb), .s_axis_tkeep(p_s_tkeep), .s_axis_tlast(p_s_tlast),
      .s_axis_tid(p_s_tid), .s_axis_tdest(p_s_tdest), .s_axis_tuser(p_s_tuser),
      .m_axis_tvalid(p_m_tvalid), .m_axis_tready(p_m_tready), .m_axis_tdata(p_m_tdata),
      .m_axis_tstrb(p_m_tstrb), .m_axis_tkeep(p_m_tkeep), .m_axis_tlast(p_m_tlast),
      .m_axis_tid(p_m_tid), .m_axis_tdest(p_m_tdest), .m_axis_tuser(p_m_tuser),
      .occupancy(p_occ), .pkt_drop(p_drop), .full(p_full), .empty(p_empty)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic p_drive(input logic v, input logic [31:0] d, input logic l);
      p_s_tvalid = v;
      p_s_tdata  = d;
      p_s_tlast  = l;
      p_s_tstrb  = 4'hF;
      p_s_tkeep  = 4'hF;
      p_s_tid    = d[3:0];
      p_s_tdest  = d[7:4];
      p_s_tuser  = ~d[3:0];
   endtask

   task automatic test_reset();
      areset = 1'b1;
      repeat (2) @(negedge aclk);
      #1;
      checks++;
      if ({b_s_tready, b_m_tvalid, b_occ, b_full, b_empty, b_drop} !== {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0})
         $display("FAIL reset_beat got rdy=%b vld=%b occ=%0d full=%b empty=%b drop=%b want 0 0 0 0 1 0",
                  b_s_tready, b_m_tvalid, b_occ, b_full, b_empty, b_drop);
      checks++;
      if ({p_s_tready, p_m_tvalid, p_occ, p_full, p_empty, p_drop} !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0})
         $display("FAIL reset_pkt got rdy=%b vld=%b occ=%0d full=%b empty=%b drop=%b want 0 0 0 0 1 0",
                  p_s_tready, p_m_tvalid, p_occ, p_full, p_empty, p_drop);
      if (b_s_tready !== 1'b0 || b_m_tvalid !== 1'b0 || b_occ !== 5'd0 || b_empty !== 1'b1 ||
          p_s_tready !== 1'b0 || p_m_tvalid !== 1'b0 || p_occ !== 4'd0 || p_empty !== 1'b1 || p_drop !== 1'b0)
         errors++;
      areset = 1'b0;
      @(negedge aclk);
      #1;
      checks++;
      if (b_s_tready !== 1'b1 || p_s_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release tready beat=%b pkt=%b want 1 1", b_s_tready, p_s_tready);
      end
   endtask

   task automatic test_beat_fill();
      b_m_tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge aclk);
         b_s_tvalid = 1'b1; b_s_tdata = 32'(i); b_s_tlast = 1'b0;
         b_s_tkeep = 4'hF; b_s_tstrb = 4'hF; b_s_tid = 4'(i); b_s_tdest = 4'h0; b_s_tuser = 4'h0;
         #1;
         checks++;
         if (b_s_tready !== 1'b1) begin
            errors++;
            $display("FAIL fill_ready beat %0d got %b want 1", i, b_s_tready);
         end
      end
      @(negedge aclk);
      b_s_tvalid = 1'b0;
      #1;
      checks++;
      if (b_full !== 1'b1 || b_s_tready !== 1'b0 || b_occ !== 5'd16 || b_m_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL fill_full got full=%b rdy=%b occ=%0d vld=%b want 1 0 16 1", b_full, b_s_tready, b_occ, b_m_tvalid);
      end
      b_m_tready = 1'b1;
      #1;
      checks++;
      if (b_s_tready !== 1'b0) begin
         errors++;
         $display("FAIL full_pop_ready got %b want 0", b_s_tready);
      end
      for (int i = 0; i < 16; i++) begin
         if (i > 0) begin
            @(negedge aclk);
            #1;
         end
         checks++;
         if (b_m_tvalid !== 1'b1 || b_m_tdata !== 32'(i)) begin
            errors++;
            $display("FAIL drain beat %0d got vld=%b data=%0d want 1 %0d", i, b_m_tvalid, b_m_tdata, i);
         end
         if (i == 1) begin
            checks++;
            if (b_s_tready !== 1'b1) begin
               errors++;
               $display("FAIL ready_after_pop got %b want 1", b_s_tready);
            end
         end
      end
      @(negedge aclk);
      #1;
      checks++;
      if (b_empty !== 1'b1 || b_m_tvalid !== 1'b0 || b_occ !== 5'd0) begin
         errors++;
         $display("FAIL drain_empty got empty=%b vld=%b occ=%0d want 1 0 0", b_empty, b_m_tvalid, b_occ);
      end
      b_m_tready = 1'b0;
   endtask

   task automatic test_beat_stream();
      logic [3:0] ids [100];
      logic [3:0] dsts [100];
      logic [3:0] usrs [100];
      logic [48:0] exp_b;
      logic [48:0] got_b;
      int in_idx = 0, out_idx = 0, cyc = 0, max_occ = 0;
      for (int i = 0; i < 100; i++) begin
         ids[i]  = 4'($urandom);
         dsts[i] = 4'($urandom);
         usrs[i] = 4'($urandom);
      end
      while (out_idx < 100 && cyc < 400) begin
         @(negedge aclk);
         b_s_tvalid = (cyc % 2 == 0) && (in_idx < 100);
         b_s_tdata  = 32'(in_idx);
         b_s_tstrb  = 4'(in_idx);
         b_s_tkeep  = 4'hF;
         b_s_tlast  = (in_idx % 4 == 3);
         b_s_tid    = (in_idx < 100) ? ids[in_idx]  : 4'h0;
         b_s_tdest  = (in_idx < 100) ? dsts[in_idx] : 4'h0;
         b_s_tuser  = (in_idx < 100) ? usrs[in_idx] : 4'h0;
         b_m_tready = (cyc % 2 == 0);
         #1;
         if (int'(b_occ) > max_occ) max_occ = int'(b_occ);
         if (b_m_tvalid && b_m_tready) begin
            exp_b = {32'(out_idx), 4'(out_idx), 4'hF, (out_idx % 4 == 3), ids[out_idx], dsts[out_idx], usrs[out_idx]};
            got_b = {b_m_tdata, b_m_tstrb, b_m_tkeep, b_m_tlast, b_m_tid, b_m_tdest, b_m_tuser};
            checks++;
            if (got_b !== exp_b) begin
               errors++;
               $display("FAIL stream beat %0d got %h want %h", out_idx, got_b, exp_b);
            end
            out_idx++;
         end
         if (b_s_tvalid && b_s_tready) in_idx++;
         cyc++;
      end
      b_s_tvalid = 1'b0;
      b_m_tready = 1'b0;
      checks++;
      if (out_idx != 100) begin
         errors++;
         $display("FAIL stream_count got %0d want 100", out_idx);
      end
      checks++;
      if (max_occ > 2) begin
         errors++;
         $display("FAIL stream_occ got max %0d want <= 2", max_occ);
      end
   endtask

   task automatic test_pkt_basic();
      p_m_tready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge aclk);
         p_drive(1'b1, 32'(100 + k), k == 4);
         #1;
         checks++;
         if (p_m_tvalid !== 1'b0 || p_s_tready !== 1'b1) begin
            errors++;
            $display("FAIL pkt_hold beat %0d got vld=%b rdy=%b want 0 1", k, p_m_tvalid, p_s_tready);
         end
      end
      for (int j = 0; j < 5; j++) begin
         @(negedge aclk);
         p_drive(1'b0, 32'd0, 1'b0);
         #1;
         checks++;
         if (p_m_tvalid !== 1'b1 || p_m_tdata !== 32'(100 + j) || p_m_tlast !== (j == 4) ||
             p_m_tid !== 4'(100 + j)) begin
            errors++;
            $display("FAIL pkt_out beat %0d got vld=%b data=%0d last=%b id=%h want 1 %0d %b %h",
                     j, p_m_tvalid, p_m_tdata, p_m_tlast, p_m_tid, 100 + j, j == 4, 4'(100 + j));
         end
      end
      @(negedge aclk);
      #1;
      checks++;
      if (p_m_tvalid !== 1'b0 || p_empty !== 1'b1) begin
         errors++;
         $display("FAIL pkt_done got vld=%b empty=%b want 0 1", p_m_tvalid, p_empty);
      end
   endtask

   task automatic test_pkt_oversize();
      int k = 0, cyc = 0, drops = 0, drop_occ = -1;
      logic mv_seen = 1'b0, seen_drop = 1'b0, ready_gap = 1'b0;
      p_m_tready = 1'b1;
      while (k < 12 && cyc < 60) begin
         @(negedge aclk);
         p_drive(1'b1, 32'(200 + k), k == 11);
         #1;
         if (p_m_tvalid) mv_seen = 1'b1;
         if (p_drop) begin
            drops++;
            drop_occ = int'(p_occ);
            seen_drop = 1'b1;
         end else if (seen_drop && !p_s_tready) begin
            ready_gap = 1'b1;
         end
         if (p_s_tready) k++;
         cyc++;
      end
      @(negedge aclk);
      p_drive(1'b0, 32'd0, 1'b0);
      #1;
      checks++;
      if (k != 12) begin
         errors++;
         $display("FAIL oversize_sent got %0d want 12", k);
      end
      checks++;
      if (drops != 1 || drop_occ != 8) begin
         errors++;
         $display("FAIL oversize_drop got pulses=%0d occ=%0d want 1 8", drops, drop_occ);
      end
      checks++;
      if (mv_seen !== 1'b0 || ready_gap !== 1'b0) begin
         errors++;
         $display("FAIL oversize_flow got mvalid_seen=%b ready_gap=%b want 0 0", mv_seen, ready_gap);
      end
      checks++;
      if (p_occ !== 4'd0 || p_m_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL oversize_after got occ=%0d vld=%b want 0 0", p_occ, p_m_tvalid);
      end
      for (int j = 0; j < 3; j++) begin
         @(negedge aclk);
         p_drive(1'b1, 32'(300 + j), j == 2);
         #1;
      end
      for (int j = 0; j < 3; j++) begin
         @(negedge aclk);
         p_drive(1'b0, 32'd0, 1'b0);
         #1;
         checks++;
         if (p_m_tvalid !== 1'b1 || p_m_tdata !== 32'(300 + j) || p_m_tlast !== (j == 2)) begin
            errors++;
            $display("FAIL post_drop beat %0d got vld=%b data=%0d last=%b want 1 %0d %b",
                     j, p_m_tvalid, p_m_tdata, p_m_tlast, 300 + j, j == 2);
         end
      end
      @(negedge aclk);
      #1;
      p_m_tready = 1'b0;
   endtask

   task automatic test_pkt_committed_drop();
      int kb = 0, cyc = 0, pops = 0, drops = 0;
      p_m_tready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge aclk);
         p_drive(1'b1, 32'(32'hA0 + k), k == 3);
         #1;
      end
      while (kb < 10 && cyc < 100) begin
         @(negedge aclk);
         p_m_tready = (cyc >= 8);
         p_drive(1'b1, 32'(32'hB0 + kb), kb == 9);
         #1;
         if (p_drop) drops++;
         if (p_m_tvalid && p_m_tready) begin
            checks++;
            if (pops >= 4 || p_m_tdata !== 32'(32'hA0 + pops) || p_m_tlast !== (pops == 3)) begin
               errors++;
               $display("FAIL committed pop %0d got data=%h last=%b want %h %b",
                        pops, p_m_tdata, p_m_tlast, 32'hA0 + pops, pops == 3);
            end
            pops++;
         end
         if (p_s_tvalid && p_s_tready) kb++;
         cyc++;
      end
      @(negedge aclk);
      p_drive(1'b0, 32'd0, 1'b0);
      #1;
      checks++;
      if (pops != 4 || kb != 10) begin
         errors++;
         $display("FAIL committed_counts got pops=%0d sent=%0d want 4 10", pops, kb);
      end
      checks++;
      if (drops != 1) begin
         errors++;
         $display("FAIL committed_drop got %0d pulses want 1", drops);
      end
      checks++;
      if (p_occ !== 4'd0 || p_m_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL committed_after got occ=%0d vld=%b want 0 0", p_occ, p_m_tvalid);
      end
      p_m_tready = 1'b0;
   endtask

   task automatic test_reset_mid();
      p_m_tready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge aclk);
         p_drive(1'b1, 32'(32'h40 + k), 1'b0);
         #1;
      end
      @(negedge aclk);
      p_drive(1'b0, 32'd0, 1'b0);
      #1;
      checks++;
      if (p_occ !== 4'd6) begin
         errors++;
         $display("FAIL mid_occ got %0d want 6", p_occ);
      end
      areset = 1'b1;
      @(negedge aclk);
      #1;
      checks++;
      if (p_occ !== 4'd0 || p_empty !== 1'b1 || p_m_tvalid !== 1'b0 || p_drop !== 1'b0 || p_s_tready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got occ=%0d empty=%b vld=%b drop=%b rdy=%b want 0 1 0 0 0",
                  p_occ, p_empty, p_m_tvalid, p_drop, p_s_tready);
      end
      areset = 1'b0;
      @(negedge aclk);
      #1;
      checks++;
      if (p_s_tready !== 1'b1) begin
         errors++;
         $display("FAIL mid_release rdy got %b want 1", p_s_tready);
      end
      p_m_tready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge aclk);
         p_drive(1'b1, 32'(32'h55 + k), k == 1);
         #1;
      end
      for (int j = 0; j < 2; j++) begin
         @(negedge aclk);
         p_drive(1'b0, 32'd0, 1'b0);
         #1;
         checks++;
         if (p_m_tvalid !== 1'b1 || p_m_tdata !== 32'(32'h55 + j)) begin
            errors++;
            $display("FAIL mid_fresh beat %0d got vld=%b data=%h want 1 %h", j, p_m_tvalid, p_m_tdata, 32'h55 + j);
         end
      end
      p_m_tready = 1'b0;
   endtask

   initial begin
      areset = 1'b1;
      b_s_tvalid = 1'b0; b_s_tdata = '0; b_s_tstrb = '0; b_s_tkeep = '0; b_s_tlast = 1'b0;
      b_s_tid = '0; b_s_tdest = '0; b_s_tuser = '0; b_m_tready = 1'b0;
      p_drive(1'b0, 32'd0, 1'b0);
      p_m_tready = 1'b0;
      test_reset();
      test_beat_fill();
      test_beat_stream();
      test_pkt_basic();
      test_pkt_oversize();
      test_pkt_committed_drop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axis_fifo_pkt.md
Name: axis_fifo_pkt

Overview:
Parametrised synthesizable AXI-Stream FIFO for the datapath between stream producers and consumers that the master/slave BFMs exercise. It carries the full sideband (tkeep, tstrb, tlast, tid, tdest, tuser) at configurable widths and depth. It has two modes: beat mode (first-word-fall-through) and packet mode (store-and-forward), with oversize-packet drop.

Parameters:
DATA_W, 32, tdata width in bits; multiple of 8
ID_W, 1, tid width
DEST_W, 1, tdest width
USER_W, 1, tuser width
DEPTH, 16, entries; power of two, >= 4
PACKET_MODE, 0, 0 = beat FWFT; 1 = store-and-forward, output only complete packets

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous, active-high reset
s_axis_tvalid  in  1  slave stream valid
s_axis_tready  out  1  slave stream ready
s_axis_tdata  in  DATA_W  data
s_axis_tstrb  in  DATA_W/8  byte strobe
s_axis_tkeep  in  DATA_W/8  byte keep
s_axis_tlast  in  1  end of packet
s_axis_tid  in  ID_W  stream id
s_axis_tdest  in  DEST_W  routing
s_axis_tuser  in  USER_W  user sideband
m_axis_t*  out  (same set, same widths; m_axis_tready is in)  master stream
occupancy  out  $clog2(DEPTH)+1  stored beats, including uncommitted beats
pkt_drop  out  1  one-cycle pulse when a packet is discarded
full  out  1  occupancy == DEPTH
empty  out  1  occupancy == 0

Behaviour:
- Reset (areset=1 at an edge): pointers and counters are cleared. s_axis_tready=0 during reset and 1 on the first cycle after; m_axis_tvalid=0, occupancy=0, pkt_drop=0, full=0, empty=1. Reset mid-packet discards all content, with no pkt_drop pulse.
- Storage: DEPTH entries holding {tdata,tstrb,tkeep,tlast,tid,tdest,tuser}. Write pointer and read pointer are $clog2(DEPTH)+1 bits and wrap naturally. full/empty use the MSB-differ/equal compare.
- Push = s_axis_tvalid & s_axis_tready. Pop = m_axis_tvalid & m_axis_tready. occupancy updates by +push-pop every cycle.
- Beat mode:
  - s_axis_tready = !full.
  - m_axis_tvalid = !empty.
  - A beat pushed at edge N is visible on m_axis at cycle N+1 (one-cycle latency). There is no combinational bypass.
  - Simultaneous push and pop when neither full nor empty: occupancy is unchanged.
  - When full, tready=0 even if a pop occurs that cycle; tready rises the cycle after the pop.
  - m_axis outputs are read combinationally from rd_ptr and stay stable while tvalid=1 & tready=0.
- Packet mode:
  - A separate commit pointer wr_commit advances to wr_ptr+1 on a push with tlast=1.
  - The read side compares against wr_commit: m_axis_tvalid = (rd_ptr != wr_commit).
  - A single-beat packet (tlast on the first beat) is committed in that same edge and visible at N+1.
- Oversize packet (packet mode only):
  - Trigger: FIFO full and wr_commit == rd_ptr, i.e. no complete packet stored.
  - Response: wr_ptr rewinds to wr_commit, and the block enters state DROP.
  - In DROP: s_axis_tready=1; beats are accepted and discarded through tlast; occupancy excludes them.
  - pkt_drop pulses one cycle on the rewind edge.
  - DROP exits after the tlast beat, back to state ACCEPT.
  - Committed packets ahead continue draining unaffected.
- FSM (packet mode): ACCEPT -> DROP on the oversize condition; DROP -> ACCEPT on a push with tlast. Beat mode stays in ACCEPT.
- A tlast pop does not affect the write side. AXI rule: tvalid is never deasserted without a handshake.

Decomposition:
- Package axis_pkg:
  - Parametrised-width helper constants: KEEP_W = DATA_W/8; PTR_W = $clog2(DEPTH)+1.
  - typedef enum {ACCEPT, DROP} axis_fifo_state_e.
  - Function for pointer full/empty compare.
- Sub-module axis_fifo_ram: simple dual-port, one write port and asynchronous read, width = packed beat width, DEPTH entries.
- Top axis_fifo_pkt holds pointers, FSM and status.

Test Plan:
- Beat mode, DEPTH=16, m_tready=0, push 16 beats tdata=0..15 -> full=1, s_tready=0 after 16th edge, occupancy=16; then m_tready=1 -> 0..15 out in order, s_tready=1 one cycle after first pop.
- Beat mode, continuous push and pop with m_tready toggling 1010..., 100 beats with incrementing tdata, tkeep=0xF, tid/tdest/tuser random -> output sequence and sideband match input exactly; occupancy never exceeds 2.
- Packet mode, push 5-beat packet with tlast on beat 5, m_tready=1 throughout -> m_tvalid stays 0 until the cycle after the tlast push, then 5 beats stream back-to-back.
- Packet mode, DEPTH=8, push 12-beat packet -> pkt_drop pulses once at occupancy 8, beats 9-12 accepted with tready=1, m_tvalid never asserts, occupancy returns to 0; a following 3-beat packet passes intact.
- Packet mode, committed 4-beat packet stored, then a 10-beat packet with DEPTH=8 and m_tready=0 -> first packet drains intact when m_tready=1, second is dropped, pkt_drop=1 for exactly one cycle.
- Assert areset mid-packet with occupancy=6 -> next cycle occupancy=0, empty=1, m_tvalid=0, pkt_drop=0; s_tready=1 one cycle after areset deasserts.
